// File: rtl/norm_shift_pipe.sv
// Pipelined leading-zero normaliser: one registered log-shifter stage per cycle, valid/ready.
// Define NORM_SHIFT_LIMIT_EN to add in_lim, which caps the total left shift (denormal results).
module norm_shift_pipe #(
  parameter int unsigned WIDTH = 24,
  localparam int unsigned SAW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
`ifdef NORM_SHIFT_LIMIT_EN
  input  logic [SAW-1:0]   in_lim,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic [SAW-1:0]   out_sa,
  output logic             out_zero
);

  logic [SAW-1:0]   valid_q;
  logic [SAW-1:0]   zero_q;
  logic [SAW-1:0]   adv;
  logic [WIDTH-1:0] data_q [SAW];
  logic [SAW-1:0]   sa_q   [SAW];
`ifdef NORM_SHIFT_LIMIT_EN
  logic [SAW-1:0]   lim_q  [SAW-1];
`endif

  // A stage may advance if any stage at or after it is empty, or the consumer takes the last one.
  always_comb begin
    adv = '0;
    for (int k = 0; k < SAW; k++) begin
      adv[k] = out_ready;
      for (int j = k; j < SAW; j++) begin
        if (!valid_q[j]) adv[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < SAW; k++) begin : g_stage
    localparam int unsigned Sh  = 1 << (SAW - 1 - k);
    localparam int unsigned Bit = SAW - 1 - k;

    logic             v_in;
    logic             z_in;
    logic             do_shift;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_nxt;
    logic [SAW-1:0]   sa_in;
    logic [SAW-1:0]   sa_nxt;
`ifdef NORM_SHIFT_LIMIT_EN
    localparam logic [SAW-1:0] ShW = SAW'(Sh);
    logic [SAW-1:0]   lim_in;
`endif

    if (k == 0) begin : g_head
      assign v_in  = in_valid;
      assign d_in  = in_a;
      assign sa_in = '0;
      assign z_in  = ~|in_a;
`ifdef NORM_SHIFT_LIMIT_EN
      assign lim_in = in_lim;
`endif
    end else begin : g_body
      assign v_in  = valid_q[k-1];
      assign d_in  = data_q[k-1];
      assign sa_in = sa_q[k-1];
      assign z_in  = zero_q[k-1];
`ifdef NORM_SHIFT_LIMIT_EN
      assign lim_in = lim_q[k-1];
`endif
    end

    always_comb begin
      do_shift = (d_in[WIDTH-1 -: Sh] == '0);
`ifdef NORM_SHIFT_LIMIT_EN
      do_shift = do_shift && (ShW <= lim_in);
`endif
      d_nxt       = do_shift ? (d_in << Sh) : d_in;
      sa_nxt      = sa_in;
      sa_nxt[Bit] = do_shift;
      // A zero operand shifts at every stage; report it as no shift instead.
      if (k == SAW - 1 && z_in) begin
        d_nxt  = '0;
        sa_nxt = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        sa_q[k]    <= '0;
        zero_q[k]  <= 1'b0;
      end else if (adv[k]) begin
        valid_q[k] <= v_in;
        if (v_in) begin
          data_q[k] <= d_nxt;
          sa_q[k]   <= sa_nxt;
          zero_q[k] <= z_in;
        end
      end
    end

`ifdef NORM_SHIFT_LIMIT_EN
    // Remaining budget is only needed by the stages that follow.
    if (k < SAW - 1) begin : g_lim
      always_ff @(posedge clk) begin
        if (rst) begin
          lim_q[k] <= '0;
        end else if (adv[k] && v_in) begin
          lim_q[k] <= do_shift ? (lim_in - ShW) : lim_in;
        end
      end
    end
`endif
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[SAW-1];
  assign out_b     = data_q[SAW-1];
  assign out_sa    = sa_q[SAW-1];
  assign out_zero  = zero_q[SAW-1];

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Scoreboard bench for norm_shift_pipe (WIDTH=24); limit cases run when NORM_SHIFT_LIMIT_EN is set.
module tb_norm_shift_pipe;
  localparam int unsigned WIDTH = 24;
  localparam int unsigned SAW   = 5;

  typedef struct packed {
    logic [WIDTH-1:0] b;
    logic [SAW-1:0]   sa;
    logic             z;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [SAW-1:0]   lim_drv;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_b;
  logic [SAW-1:0]   out_sa;
  logic             out_zero;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  norm_shift_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
`ifdef NORM_SHIFT_LIMIT_EN
    .in_lim    (lim_drv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_b     (out_b),
    .out_sa    (out_sa),
    .out_zero  (out_zero)
  );

  // Reference: count leading zeros bit by bit, optionally capped by the budget.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [SAW-1:0] lim);
    res_t r;
    int   n;
    r = '0;
    n = 0;
    if (a == '0) begin
      r.z = 1'b1;
      return r;
    end
    while (a[WIDTH-1-n] == 1'b0) n++;
    if (n > int'(lim)) n = int'(lim);
    r.sa = SAW'(n);
    r.b  = a << n;
    return r;
  endfunction

  // One cycle: drive at the falling edge, then report handshakes and outputs for this cycle.
  task automatic drive(input logic iv, input logic [WIDTH-1:0] a, input logic [SAW-1:0] lim,
                       input logic ordy, output logic acc, output logic xfer, output res_t obs);
    @(negedge clk);
    in_valid  = iv;
    in_a      = a;
    lim_drv   = lim;
    out_ready = ordy;
    #1;
    acc    = in_valid && in_ready;
    xfer   = out_valid && out_ready;
    obs.b  = out_b;
    obs.sa = out_sa;
    obs.z  = out_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; out_ready = 1'b1; lim_drv = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_b !== '0) begin n_fail++; $display("FAIL reset_out_b: got %h expected 000000", out_b); end
    n_checks++;
    if (out_sa !== '0) begin n_fail++; $display("FAIL reset_out_sa: got %0d expected 0", out_sa); end
    n_checks++;
    if (out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_out_zero: got %b expected 0", out_zero); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] vec [3];
    res_t             tab [3];
    logic acc, xfer;
    res_t obs, exp_r;
    int   lat;
    vec[0] = 24'h000001; tab[0] = '{b: 24'h800000, sa: 5'd23, z: 1'b0};
    vec[1] = 24'h800000; tab[1] = '{b: 24'h800000, sa: 5'd0,  z: 1'b0};
    vec[2] = 24'h000000; tab[2] = '{b: 24'h000000, sa: 5'd0,  z: 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vec[i], 5'd31, 1'b1, acc, xfer, obs);
      if (acc) sb.push_back(tab[i]);
      n_checks++;
      if (!acc) begin n_fail++; $display("FAIL single_accept[%0d]: got 0 expected 1", i); end
      lat = -1;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
        drive(1'b0, '0, 5'd31, 1'b1, acc, xfer, obs);
        if (xfer) begin
          lat = c;
          exp_r = (sb.size() > 0) ? sb.pop_front() : '0;
          n_checks++;
          if (obs !== exp_r) begin
            n_fail++;
            $display("FAIL single_result[%0d]: got b=%h sa=%0d z=%b expected b=%h sa=%0d z=%b",
                     i, obs.b, obs.sa, obs.z, exp_r.b, exp_r.sa, exp_r.z);
          end
        end
      end
      n_checks++;
      if (lat != 5) begin n_fail++; $display("FAIL single_latency[%0d]: got %0d expected 5", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] vec [4];
    res_t             tab [4];
    logic acc, xfer;
    res_t obs, exp_r;
    int   idx, got, first, last;
    vec[0] = 24'h00F000; tab[0] = '{b: 24'hF00000, sa: 5'd8,  z: 1'b0};
    vec[1] = 24'h3FFFFF; tab[1] = '{b: 24'hFFFFFC, sa: 5'd2,  z: 1'b0};
    vec[2] = 24'h000100; tab[2] = '{b: 24'h800000, sa: 5'd15, z: 1'b0};
    vec[3] = 24'h400000; tab[3] = '{b: 24'h800000, sa: 5'd1,  z: 1'b0};
    idx = 0; got = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      drive(idx < 4, (idx < 4) ? vec[idx] : '0, 5'd31, 1'b1, acc, xfer, obs);
      if (acc) begin sb.push_back(tab[idx]); idx++; end
      if (xfer) begin
        if (first < 0) first = cyc;
        last = cyc;
        exp_r = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (obs !== exp_r) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got b=%h sa=%0d expected b=%h sa=%0d",
                   got, obs.b, obs.sa, exp_r.b, exp_r.sa);
        end
        got++;
      end
    end
    n_checks++;
    if (got != 4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", got); end
    n_checks++;
    if (last - first != 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 3", last - first); end
  endtask

  task automatic test_backpressure();
    logic acc, xfer, ordy, held_v, stall_seen;
    logic [WIDTH-1:0] a;
    res_t obs, exp_r, held;
    int   sent, got, extra;
    sent = 0; got = 0; held_v = 1'b0; stall_seen = 1'b0; held = '0;
    for (int cyc = 0; cyc < 80 && got < 12; cyc++) begin
      ordy = !(cyc >= 3 && cyc < 10);
      a = 24'($urandom() >> $urandom_range(8, 31));
      drive(sent < 12, a, 5'd31, ordy, acc, xfer, obs);
      if (held_v) begin
        n_checks++;
        if (obs !== held) begin
          n_fail++;
          $display("FAIL bp_hold: got b=%h sa=%0d expected b=%h sa=%0d", obs.b, obs.sa, held.b, held.sa);
        end
      end
      held_v = out_valid && !ordy;
      held   = obs;
      if (!in_ready && sent < 12) stall_seen = 1'b1;
      if (acc) begin sb.push_back(model(a, 5'd31)); sent++; end
      if (xfer) begin
        exp_r = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (obs !== exp_r) begin
          n_fail++;
          $display("FAIL bp_result[%0d]: got b=%h sa=%0d z=%b expected b=%h sa=%0d z=%b",
                   got, obs.b, obs.sa, obs.z, exp_r.b, exp_r.sa, exp_r.z);
        end
        got++;
      end
    end
    n_checks++;
    if (got != 12) begin n_fail++; $display("FAIL bp_count: got %0d expected 12", got); end
    n_checks++;
    if (!stall_seen) begin n_fail++; $display("FAIL bp_in_ready_low: got 0 expected 1"); end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL bp_leftover: got %0d expected 0", sb.size()); end

    // Fill under stall, then reset: nothing in flight may come out afterwards.
    for (int cyc = 0; cyc < 8; cyc++) begin
      a = 24'($urandom() >> $urandom_range(8, 31));
      drive(1'b1, a, 5'd31, 1'b0, acc, xfer, obs);
      if (acc) sb.push_back(model(a, 5'd31));
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_valid: got %b expected 0", out_valid); end
    rst = 1'b0;
    sb.delete();
    extra = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      drive(1'b0, '0, 5'd31, 1'b1, acc, xfer, obs);
      if (xfer) extra++;
    end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL rst_stale_out: got %0d expected 0", extra); end
  endtask

`ifdef NORM_SHIFT_LIMIT_EN
  task automatic test_limit();
    logic [SAW-1:0] lims [3];
    logic [WIDTH-1:0] vec [3];
    res_t tab [3];
    logic acc, xfer;
    res_t obs, exp_r;
    int   idx, got;
    vec[0] = 24'h000010; lims[0] = 5'd5;  tab[0] = '{b: 24'h000200, sa: 5'd5,  z: 1'b0};
    vec[1] = 24'h000010; lims[1] = 5'd31; tab[1] = '{b: 24'h800000, sa: 5'd19, z: 1'b0};
    vec[2] = 24'h000000; lims[2] = 5'd7;  tab[2] = '{b: 24'h000000, sa: 5'd0,  z: 1'b1};
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      drive(idx < 3, (idx < 3) ? vec[idx] : '0, (idx < 3) ? lims[idx] : 5'd0, 1'b1, acc, xfer, obs);
      if (acc) begin sb.push_back(tab[idx]); idx++; end
      if (xfer) begin
        exp_r = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (obs !== exp_r) begin
          n_fail++;
          $display("FAIL limit_result[%0d]: got b=%h sa=%0d z=%b expected b=%h sa=%0d z=%b",
                   got, obs.b, obs.sa, obs.z, exp_r.b, exp_r.sa, exp_r.z);
        end
        got++;
      end
    end
    n_checks++;
    if (got != 3) begin n_fail++; $display("FAIL limit_count: got %0d expected 3", got); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
`ifdef NORM_SHIFT_LIMIT_EN
    test_limit();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
